// File: rtl/iiitb_sdm.sv
// rtl/iiitb_sdm.sv - Moore sequence detector for serial pattern 1-0-1-1 with overlap
//
// Ports:
//   clock         in   system clock, all state updates on rising edge
//   reset         in   synchronous active-low reset (0 = reset)
//   sequence_in   in   serial data bit, one per rising edge
//   detector_out  out  high for one cycle after the last four bits were 1,0,1,1

module iiitb_sdm (
    input  logic clock,
    input  logic reset,
    input  logic sequence_in,
    output logic detector_out
);

    // Each state names the longest suffix of the input that is a prefix of 1011.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_e;

    state_e state_d;
    state_e state_q;

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = sequence_in ? S1 : S0;
            S1:      state_d = sequence_in ? S1 : S2;
            S2:      state_d = sequence_in ? S3 : S0;
            S3:      state_d = sequence_in ? S4 : S2;
            // The trailing 1 of a match starts the next candidate.
            S4:      state_d = sequence_in ? S1 : S2;
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Decoded from the state register only, so it cannot glitch on sequence_in.
    assign detector_out = (state_q == S4);

endmodule

// File: tb/tb_iiitb_sdm.sv
// tb/tb_iiitb_sdm.sv - self-checking bench for iiitb_sdm

module tb_iiitb_sdm;

    logic clock;
    logic reset;
    logic sequence_in;
    logic detector_out;

    int n_cmp;
    int n_fail;

    // Reference model: the last four sampled bits and how many bits since reset.
    logic [3:0] hist;
    int         nbits;
    logic       exp_out;

    iiitb_sdm dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .detector_out (detector_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one bit on the falling edge, let the rising edge sample it, then
    // advance the model and return what the output should now show.
    task automatic step(input logic b, input logic r, output logic e);
        @(negedge clock);
        sequence_in = b;
        reset       = r;
        @(posedge clock);
        #1;
        if (!r) begin
            hist  = 4'b0000;
            nbits = 0;
        end else begin
            hist  = {hist[2:0], b};
            nbits = nbits + 1;
        end
        e = (nbits >= 4) && (hist == 4'b1011);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(i[0], 1'b0, exp_out);
            n_cmp++;
            if (detector_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b expected 0", i, detector_out);
            end
        end
    endtask

    task automatic test_basic();
        logic [4:0] bits;
        int pulses;
        bits   = 5'b10110;
        pulses = 0;
        for (int i = 4; i >= 0; i--) begin
            step(bits[i], 1'b1, exp_out);
            if (detector_out === 1'b1) pulses++;
            n_cmp++;
            if (detector_out !== exp_out) begin
                n_fail++;
                $display("FAIL basic bit%0d: got %b expected %b", 5 - i, detector_out, exp_out);
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL basic_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_overlap();
        logic [10:0] bits;
        int pulses;
        step(1'b0, 1'b0, exp_out);
        bits   = 11'b01010110100;
        pulses = 0;
        for (int i = 10; i >= 0; i--) begin
            step(bits[i], 1'b1, exp_out);
            if (detector_out === 1'b1) pulses++;
            n_cmp++;
            if (detector_out !== exp_out) begin
                n_fail++;
                $display("FAIL overlap bit%0d: got %b expected %b", 11 - i, detector_out, exp_out);
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL overlap_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_chained();
        logic [6:0] bits;
        int pulses;
        step(1'b0, 1'b0, exp_out);
        bits   = 7'b1011011;
        pulses = 0;
        for (int i = 6; i >= 0; i--) begin
            step(bits[i], 1'b1, exp_out);
            if (detector_out === 1'b1) pulses++;
            n_cmp++;
            if (detector_out !== exp_out) begin
                n_fail++;
                $display("FAIL chained bit%0d: got %b expected %b", 7 - i, detector_out, exp_out);
            end
        end
        n_cmp++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL chained_pulses: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_non_patterns();
        logic [12:0] bits;
        step(1'b0, 1'b0, exp_out);
        bits = 13'b1111000010011;
        for (int i = 12; i >= 0; i--) begin
            step(bits[i], 1'b1, exp_out);
            n_cmp++;
            if (detector_out !== 1'b0) begin
                n_fail++;
                $display("FAIL nonpattern bit%0d: got %b expected 0", 13 - i, detector_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] bits;
        bits = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            step(bits[i], 1'b1, exp_out);
        end
        step(1'b1, 1'b0, exp_out);
        step(1'b1, 1'b1, exp_out);
        n_cmp++;
        if (detector_out !== 1'b0 || exp_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_discard: got %b expected 0", detector_out);
        end
        // Build a fresh match, then reset on the following edge.
        step(1'b0, 1'b1, exp_out);
        step(1'b1, 1'b1, exp_out);
        step(1'b1, 1'b1, exp_out);
        n_cmp++;
        if (detector_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_match: got %b expected 1", detector_out);
        end
        step(1'b1, 1'b0, exp_out);
        n_cmp++;
        if (detector_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after_match: got %b expected 0", detector_out);
        end
    endtask

    task automatic test_random();
        logic b;
        logic r;
        for (int i = 0; i < 400; i++) begin
            b = 1'($urandom_range(1, 0));
            r = ($urandom_range(31, 0) != 0);
            step(b, r, exp_out);
            n_cmp++;
            if (detector_out !== exp_out) begin
                n_fail++;
                $display("FAIL random[%0d] in=%b rst=%b: got %b expected %b",
                         i, b, r, detector_out, exp_out);
            end
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        hist        = 4'b0000;
        nbits       = 0;
        reset       = 1'b0;
        sequence_in = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_chained();
        test_non_patterns();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
